// File: rtl/axis_bram_adapter_v1_0_seq_if.sv
// Command, stream and controller-programming signals of the BRAM adapter sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic's view.
interface axis_bram_adapter_v1_0_seq_if #(
  parameter int BRAM_ADDR_LENGTH = 12
);
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic                        cmd_rw;
  logic [BRAM_ADDR_LENGTH-1:0] cmd_start_index;
  logic [BRAM_ADDR_LENGTH-1:0] cmd_bound_index;
  logic                        cmd_abort;
  logic                        s_valid;
  logic                        s_ready;
  logic                        m_valid;
  logic                        m_ready;
  logic                        m_last;
  logic                        ctl_rw;
  logic                        ctl_addr_reload;
  logic [BRAM_ADDR_LENGTH-1:0] ctl_start_index;
  logic [BRAM_ADDR_LENGTH-1:0] ctl_bound_index;
  logic                        ctl_stream_in_valid;
  logic                        ctl_stream_out_accep;
  logic                        ctl_stream_in_accep;
  logic                        ctl_stream_out_valid;
  logic                        ctl_stream_out_tlast;

  modport slave (
    input  cmd_valid, cmd_rw, cmd_start_index, cmd_bound_index, cmd_abort,
    input  s_valid, m_ready,
    input  ctl_stream_in_accep, ctl_stream_out_valid, ctl_stream_out_tlast,
    output cmd_ready, s_ready, m_valid, m_last,
    output ctl_rw, ctl_addr_reload, ctl_start_index, ctl_bound_index,
    output ctl_stream_in_valid, ctl_stream_out_accep
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_start_index, cmd_bound_index, cmd_abort,
    output s_valid, m_ready,
    output ctl_stream_in_accep, ctl_stream_out_valid, ctl_stream_out_tlast,
    input  cmd_ready, s_ready, m_valid, m_last,
    input  ctl_rw, ctl_addr_reload, ctl_start_index, ctl_bound_index,
    input  ctl_stream_in_valid, ctl_stream_out_accep
  );
endinterface

// File: rtl/axis_bram_adapter_v1_0_seq.sv
// Transfer sequencer for the BRAM adapter controller: runs one command at a time,
// flushes and reloads the controller, gates stream beats and reports completion.
module axis_bram_adapter_v1_0_seq #(
  parameter int BRAM_ADDR_LENGTH   = 12,
  parameter int BRAM_WIDTH_IN_WORD = 36
) (
  input  logic                        clk,
  input  logic                        rstn,
  axis_bram_adapter_v1_0_seq_if.slave bus,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  err,
  output logic [BRAM_ADDR_LENGTH:0]   lines_done
);
  localparam int AW = BRAM_ADDR_LENGTH;
  localparam int WW = (BRAM_WIDTH_IN_WORD > 1) ? $clog2(BRAM_WIDTH_IN_WORD) : 1;
  localparam logic [WW-1:0] WORD_LAST = WW'(BRAM_WIDTH_IN_WORD - 1);
  localparam logic [AW:0]   ONE_LINE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_LOAD, S_SETTLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t        r_state;
  logic          r_dir;
  logic          r_ctl_rw;
  logic          r_reload;
  logic          r_cmd_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_drain;
  logic [AW-1:0] r_start;
  logic [AW-1:0] r_bound;
  logic [AW:0]   r_total;
  logic [AW:0]   r_lines;
  logic [WW-1:0] r_word;
  logic [1:0]    r_err;

  logic          w_run_wr;
  logic          w_run_rd;
  logic          w_hs;
  logic          w_wrap;
  logic          w_wr_last;
  logic          w_rd_last;
  logic          w_complete;
  logic          w_abort;
  logic          w_range_err;
  logic [AW:0]   w_lines_inc;

  // Stream gating is purely combinational so a beat sees no extra latency.
  assign w_run_wr = (r_state == S_RUN) && r_dir;
  assign w_run_rd = (r_state == S_RUN) && !r_dir;

  assign bus.ctl_stream_in_valid  = w_run_wr && bus.s_valid;
  assign bus.s_ready              = w_run_wr && bus.ctl_stream_in_accep;
  assign bus.m_valid              = w_run_rd && bus.ctl_stream_out_valid;
  assign bus.ctl_stream_out_accep = w_run_rd && bus.m_ready;
  assign bus.m_last               = bus.m_valid && bus.ctl_stream_out_tlast;

  assign w_hs        = (bus.s_valid && bus.s_ready) || (bus.m_valid && bus.m_ready);
  assign w_wrap      = w_hs && (r_word == WORD_LAST);
  assign w_lines_inc = r_lines + ONE_LINE;
  assign w_wr_last   = w_run_wr && w_wrap && (w_lines_inc == r_total);
  assign w_rd_last   = bus.m_ready && bus.m_last;
  assign w_complete  = w_wr_last || w_rd_last;
  assign w_abort     = bus.cmd_abort && r_busy && (r_state != S_DONE);
  assign w_range_err = bus.cmd_bound_index < bus.cmd_start_index;

  assign bus.cmd_ready       = r_cmd_ready;
  assign bus.ctl_rw          = r_ctl_rw;
  assign bus.ctl_addr_reload = r_reload;
  assign bus.ctl_start_index = r_start;
  assign bus.ctl_bound_index = r_bound;
  assign busy                = r_busy;
  assign done                = r_done;
  assign err                 = r_err;
  assign lines_done          = r_lines;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b1;
      r_ctl_rw    <= 1'b1;
      r_reload    <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_drain     <= 1'b0;
      r_start     <= '0;
      r_bound     <= '0;
      r_total     <= '0;
      r_lines     <= '0;
      r_word      <= '0;
      r_err       <= 2'b00;
    end else begin
      r_reload <= 1'b0;
      r_done   <= 1'b0;
      if (w_hs) begin
        r_word <= w_wrap ? '0 : r_word + WW'(1);
        if (w_wrap) r_lines <= w_lines_inc;
      end
      // A completing handshake outranks a simultaneous abort.
      if (w_abort && !w_complete) begin
        r_state <= S_DONE;
        r_err   <= 2'b10;
        r_done  <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.cmd_valid) begin
              r_dir       <= bus.cmd_rw;
              r_start     <= bus.cmd_start_index;
              r_bound     <= bus.cmd_bound_index;
              r_total     <= {1'b0, bus.cmd_bound_index} - {1'b0, bus.cmd_start_index} + ONE_LINE;
              r_lines     <= '0;
              r_word      <= '0;
              r_cmd_ready <= 1'b0;
              r_busy      <= 1'b1;
              if (w_range_err) begin
                r_err   <= 2'b01;
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_err    <= 2'b00;
                r_state  <= S_FLUSH;
                r_ctl_rw <= ~bus.cmd_rw;
              end
            end
          end
          S_FLUSH: begin
            // Returning rw to dir gives the controller the edge that clears its word counter.
            r_state  <= S_LOAD;
            r_ctl_rw <= r_dir;
            r_reload <= 1'b1;
          end
          S_LOAD:   r_state <= S_SETTLE;
          S_SETTLE: r_state <= S_RUN;
          S_RUN: begin
            if (w_wr_last) begin
              r_state <= S_DRAIN;
              r_drain <= 1'b0;
            end else if (w_rd_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
          S_DRAIN: begin
            if (r_drain) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_drain <= 1'b1;
            end
          end
          S_DONE: begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axis_bram_adapter_v1_0_seq.sv
// Scoreboard bench for the BRAM adapter sequencer with a small behavioural controller model.
module tb_axis_bram_adapter_v1_0_seq;
  localparam int AW  = 12;
  localparam int WPL = 36;

  logic        clk;
  logic        rstn;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [AW:0] lines_done;

  axis_bram_adapter_v1_0_seq_if #(.BRAM_ADDR_LENGTH(AW)) bus ();

  axis_bram_adapter_v1_0_seq #(
    .BRAM_ADDR_LENGTH(AW),
    .BRAM_WIDTH_IN_WORD(WPL)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus),
    .busy(busy),
    .done(done),
    .err(err),
    .lines_done(lines_done)
  );

  typedef struct {
    logic [1:0] err;
    int lines;
    int beats;
    int lat_ref;    // 0: from accept, 1: from last handshake
    int lat;
    int reloads;
    int ridx;
    int lasts;
    int last_beat;
    int commits;
    int caddr;
    bit chkword;
  } exp_t;

  exp_t sb_q[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int viol = 0;
  int last_done_cyc = -10;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: word counter cleared on any rw edge, line address loaded on reload.
  logic          c_rw_q;
  logic [5:0]    c_word;
  logic [AW-1:0] c_addr;
  logic [AW-1:0] c_commit_addr;
  int            c_commits = 0;
  logic          c_beat;

  assign bus.ctl_stream_in_accep  = 1'b1;
  assign bus.ctl_stream_out_valid = ~bus.ctl_rw;
  assign bus.ctl_stream_out_tlast = (c_addr == bus.ctl_bound_index) && (c_word == 6'(WPL - 1));
  assign c_beat = bus.ctl_rw ? (bus.ctl_stream_in_valid && bus.ctl_stream_in_accep)
                             : (bus.ctl_stream_out_valid && bus.ctl_stream_out_accep);

  always @(posedge clk) begin
    if (!rstn) begin
      c_rw_q <= 1'b1;
      c_word <= '0;
      c_addr <= '0;
    end else begin
      c_rw_q <= bus.ctl_rw;
      if (bus.ctl_addr_reload) c_addr <= bus.ctl_start_index;
      if (bus.ctl_rw != c_rw_q) begin
        c_word <= '0;
      end else if (c_beat) begin
        if (c_word == 6'(WPL - 1)) begin
          c_word <= '0;
          if (!bus.ctl_addr_reload) c_addr <= c_addr + 1'b1;
          if (bus.ctl_rw) begin
            c_commits     <= c_commits + 1;
            c_commit_addr <= c_addr;
          end
        end else begin
          c_word <= c_word + 1'b1;
        end
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Monitor: tracks the running command and checks each done pulse against the scoreboard.
  initial begin : monitor
    exp_t e;
    bit   in_cmd = 0;
    bit   rdy_chk = 0;
    bit   gates;
    int   acc_cyc = 0, beats = 0, lasts = 0, last_beat = 0, last_hs = 0;
    int   reloads = 0, reload_cyc = 0, reload_idx = 0, commits0 = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        in_cmd  = 0;
        rdy_chk = 0;
      end else begin
        if (rdy_chk) begin
          chk("ready_after_done", {bus.cmd_ready, busy, done}, 3'b100);
          rdy_chk = 0;
        end
        gates = bus.s_ready | bus.m_valid | bus.m_last | bus.ctl_stream_in_valid | bus.ctl_stream_out_accep;
        if (bus.cmd_ready == busy) viol++;
        if (bus.m_last && !bus.m_valid) viol++;
        if (gates && (!busy || done || (in_cmd && cyc - acc_cyc >= 1 && cyc - acc_cyc <= 3))) viol++;
        if (in_cmd) begin
          if ((bus.s_valid && bus.s_ready) || (bus.m_valid && bus.m_ready)) begin
            beats++;
            last_hs = cyc;
            if (bus.m_last && bus.m_ready) begin
              lasts++;
              last_beat = beats;
            end
          end
          if (bus.ctl_addr_reload) begin
            reloads++;
            reload_cyc = cyc;
            reload_idx = int'(bus.ctl_start_index);
          end
        end
        if (done) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("err", err, e.err);
            chk("lines_done", lines_done, e.lines);
            chk("beats", beats, e.beats);
            chk("done_latency", cyc - ((e.lat_ref == 1) ? last_hs : acc_cyc), e.lat);
            chk("reloads", reloads, e.reloads);
            if (e.reloads > 0) begin
              chk("reload_cycle", reload_cyc - acc_cyc, 2);
              chk("reload_index", reload_idx, e.ridx);
            end
            chk("tlast_count", lasts, e.lasts);
            if (e.lasts > 0) chk("tlast_beat", last_beat, e.last_beat);
            chk("line_commits", c_commits - commits0, e.commits);
            if (e.commits > 0) chk("commit_addr", c_commit_addr, e.caddr);
            if (e.chkword) chk("ctl_word_at_done", c_word, 0);
            chk("protocol", viol, 0);
          end
          in_cmd        = 0;
          rdy_chk       = 1;
          last_done_cyc = cyc;
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          in_cmd    = 1;
          acc_cyc   = cyc;
          beats     = 0;
          lasts     = 0;
          last_beat = 0;
          reloads   = 0;
          commits0  = c_commits;
        end
      end
    end
  end

  task automatic push(input logic [1:0] er, input int ln, input int bt, input int lref, input int lat,
                      input int rl, input int ridx, input int ls, input int lb, input int cm,
                      input int ca, input bit cw);
    exp_t e;
    e.err = er; e.lines = ln; e.beats = bt; e.lat_ref = lref; e.lat = lat;
    e.reloads = rl; e.ridx = ridx; e.lasts = ls; e.last_beat = lb;
    e.commits = cm; e.caddr = ca; e.chkword = cw;
    sb_q.push_back(e);
  endtask

  task automatic issue(input bit rw, input int st, input int bd, input bit hold, output int acc);
    bus.cmd_rw          = rw;
    bus.cmd_start_index = AW'(st);
    bus.cmd_bound_index = AW'(bd);
    bus.cmd_valid       = 1'b1;
    acc = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit tog);
    bit ok = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
      if (tog) bus.m_ready = ~bus.m_ready;
    end
    if (!ok) chk("done_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_beats(input int nb);
    int cnt = 0;
    for (int n = 0; n < 1000 && cnt < nb; n++) begin
      @(negedge clk);
      if ((bus.s_valid && bus.s_ready) || (bus.m_valid && bus.m_ready)) cnt++;
    end
    if (cnt != nb) chk("beat_timeout", cnt, nb);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_lines_done"}, lines_done, 0);
    chk({tag, "_ctl_rw"}, bus.ctl_rw, 1);
    chk({tag, "_ctl_start"}, bus.ctl_start_index, 0);
    chk({tag, "_ctl_bound"}, bus.ctl_bound_index, 0);
    chk({tag, "_reload"}, bus.ctl_addr_reload, 0);
    chk({tag, "_gates"}, {bus.s_ready, bus.m_valid, bus.m_last,
                          bus.ctl_stream_in_valid, bus.ctl_stream_out_accep}, 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a, b;
    rstn                = 1'b0;
    bus.cmd_valid       = 1'b0;
    bus.cmd_rw          = 1'b0;
    bus.cmd_start_index = '0;
    bus.cmd_bound_index = '0;
    bus.cmd_abort       = 1'b0;
    bus.s_valid         = 1'b0;
    bus.m_ready         = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;

    // Write lines 5..6 with s_valid held high
    bus.s_valid = 1'b1;
    push(2'b00, 2, 72, 1, 3, 1, 5, 0, 0, 2, 6, 1);
    issue(1'b1, 5, 6, 1'b0, a);
    wait_idle(1'b0);

    // Read lines 5..6 with m_ready toggling every cycle
    push(2'b00, 2, 72, 1, 1, 1, 5, 1, 72, 0, 0, 1);
    issue(1'b0, 5, 6, 1'b0, a);
    wait_idle(1'b1);

    // Range error
    push(2'b01, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    issue(1'b1, 10, 3, 1'b0, a);
    wait_idle(1'b0);

    // Abort a write after 20 beats
    push(2'b10, 0, 20, 1, 2, 1, 3, 0, 0, 0, 0, 0);
    issue(1'b1, 3, 40, 1'b0, a);
    wait_beats(20);
    @(posedge clk); #1;
    bus.s_valid   = 1'b0;
    bus.cmd_abort = 1'b1;
    @(posedge clk); #1;
    bus.cmd_abort = 1'b0;
    bus.s_valid   = 1'b1;
    wait_idle(1'b0);

    // Single-line write after the abort must start on a clean controller counter
    push(2'b00, 1, 36, 1, 3, 1, 0, 0, 0, 1, 0, 1);
    issue(1'b1, 0, 0, 1'b0, a);
    wait_idle(1'b0);

    // Back-to-back: write 1..1 then read 2..2 with cmd_valid held
    bus.m_ready = 1'b1;
    push(2'b00, 1, 36, 1, 3, 1, 1, 0, 0, 1, 1, 1);
    issue(1'b1, 1, 1, 1'b1, a);
    push(2'b00, 1, 36, 1, 1, 1, 2, 1, 36, 0, 0, 1);
    issue(1'b0, 2, 2, 1'b0, b);
    chk("b2b_accept_gap", b - last_done_cyc, 1);
    wait_idle(1'b0);

    // Reset in the middle of a read: no done pulse may follow
    issue(1'b0, 5, 6, 1'b0, a);
    wait_beats(10);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check_reset("midreset");
    repeat (20) @(posedge clk);
    #1;

    chk("scoreboard_empty", sb_q.size(), 0);
    chk("protocol_final", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/axis_bram_adapter_v1_0_seq.md
# axis_bram_adapter_v1_0_seq

Transfer sequencer that sits directly upstream of `axis_bram_adapter_v1_0_cntl`, the BRAM adapter controller.
- Accepts one transfer command at a time (direction, start line, bound line), programs the controller via `rw`, `addr_reload` and the index buses, and flushes the controller's word counter.
- Gates the AXI-Stream handshakes so beats pass only while a transfer is running.
- Detects completion (line count on write, tlast on read) and reports done/error status.

## Interface

Parameters:
- `BRAM_ADDR_LENGTH`, 12, line index width; must match the controller.
- `BRAM_WIDTH_IN_WORD`, 36, words per BRAM line; must match the controller.

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset, synchronous, active-low
- `cmd_valid`  in  1  command valid
- `cmd_ready`  out  1  command ready; high only in IDLE
- `cmd_rw`  in  1  direction: 1 = stream-in to BRAM (write), 0 = BRAM to stream-out (read)
- `cmd_start_index`  in  BRAM_ADDR_LENGTH  first line
- `cmd_bound_index`  in  BRAM_ADDR_LENGTH  last line, inclusive
- `cmd_abort`  in  1  abort the running transfer
- `s_valid`  in  1  upstream stream valid
- `s_ready`  out  1  upstream stream ready
- `m_valid`  out  1  downstream stream valid
- `m_ready`  in  1  downstream stream ready
- `m_last`  out  1  downstream tlast
- `ctl_rw`  out  1  drives controller `rw`
- `ctl_addr_reload`  out  1  drives controller `addr_reload`
- `ctl_start_index`  out  BRAM_ADDR_LENGTH  drives controller start index
- `ctl_bound_index`  out  BRAM_ADDR_LENGTH  drives controller bound index
- `ctl_stream_in_valid`  out  1  gated `s_valid` to the controller
- `ctl_stream_out_accep`  out  1  gated `m_ready` to the controller
- `ctl_stream_in_accep`  in  1  from the controller
- `ctl_stream_out_valid`  in  1  from the controller
- `ctl_stream_out_tlast`  in  1  from the controller
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  2  status of the last transfer: 00 ok, 01 range error, 10 aborted; held until the next command is accepted
- `lines_done`  out  BRAM_ADDR_LENGTH+1  full lines transferred in the current or last command

## Operation

- FSM states: IDLE, FLUSH, LOAD, SETTLE, RUN, DRAIN, DONE.
- On command accept, latch `dir` and both indices; clear `err`, `lines_done` and the word counter.
- IDLE → DONE with `err`=01 if bound < start (unsigned). No reload is issued and the gates stay closed.
- IDLE → FLUSH otherwise.
- FLUSH: `ctl_rw` = ~dir for one cycle.
- LOAD: `ctl_rw` = dir and `ctl_addr_reload` = 1 for one cycle. The rw edge clears the controller's word counter; the reload loads `ctl_start_index`.
- SETTLE: one cycle with `ctl_rw` = dir, then → RUN.
- RUN, write (dir=1):
  - `ctl_stream_in_valid` = `s_valid`; `s_ready` = `ctl_stream_in_accep`.
  - Each handshake increments the word counter, 0..BRAM_WIDTH_IN_WORD-1. On wrap, `lines_done` increments.
  - When `lines_done` reaches bound-start+1, → DRAIN on the same edge as the final handshake.
- RUN, read (dir=0):
  - `m_valid` = `ctl_stream_out_valid`; `ctl_stream_out_accep` = `m_ready`; `m_last` = `ctl_stream_out_tlast` & `m_valid`.
  - Lines are counted the same way as on write.
  - A handshake with `m_last` high → DONE.
- DRAIN (write only): two cycles so the controller commits the final line, then → DONE.
- DONE: `done` = 1 for one cycle, then → IDLE.
- Outside RUN, all gated outputs are 0: `s_ready`, `m_valid`, `m_last`, `ctl_stream_in_valid`, `ctl_stream_out_accep`.
- In IDLE, `ctl_rw` holds its last value; the index outputs hold the last latched values.
- `cmd_abort` in FLUSH, LOAD, SETTLE, RUN or DRAIN → DONE with `err`=10, and the gates close immediately.
- `cmd_abort` in IDLE or DONE is ignored.
- If abort coincides with the completing handshake, completion wins and `err`=00.
- Index arithmetic: bound-start+1 is computed in BRAM_ADDR_LENGTH+1 bits. Start=0 with bound=2^BRAM_ADDR_LENGTH-1 yields 2^BRAM_ADDR_LENGTH lines with no overflow.

## Timing

- All gated stream signals are combinational from state and inputs; they add no latency to a beat.
- Command accepted at edge T: FLUSH in cycle T+1, LOAD (reload pulse) in T+2, SETTLE in T+3, RUN from T+4.
- Range error: `done` in cycle T+1, `cmd_ready` high again in T+2.
- Write: last handshake in cycle N, DRAIN in N+1 and N+2, `done` in N+3.
- Read: last (tlast) handshake in cycle N, `done` in N+1.
- Reset values: `cmd_ready`=1 (IDLE), `ctl_rw`=1, indices 0, `err`=00, `lines_done`=0; every other output is 0.
- Reset mid-operation aborts silently with no `done`. The controller shares `rstn` and resets in the same cycle.

## Test plan

- Write, start=5, bound=6, `s_valid` held high: one reload with start 5, 72 beats accepted, `done` 3 cycles after beat 72, `lines_done`=2, `err`=00.
- Read, start=5, bound=6, `m_ready` toggling every cycle: exactly 72 beats, `m_last` only on beat 72, `done` the next cycle, no `m_valid` outside RUN.
- Range error, start=10, bound=3: `done` with `err`=01 one cycle after accept, `ctl_addr_reload` never high, `s_ready`/`m_valid` stay 0.
- Abort after 20 write beats: `done` with `err`=10, `lines_done`=0. A following write of start=0, bound=0 accepts exactly 36 beats, and the line lands at index 0 (controller counter flushed).
- Back-to-back commands with `cmd_valid` held high: `cmd_ready` low while busy, second command accepted the cycle after `done`, FLUSH/LOAD sequence repeats.
- Reset one cycle mid-read after 10 beats: all outputs at reset values next cycle, `busy`=0, no `done` pulse.
